// File: rtl/seg8_display_mux.sv
// Scans eight latched 6-bit digit codes onto a multiplexed common-anode 7-segment display.
// Each digit slot starts with a dead-time where all anodes are off, and the whole display can blink.
module seg8_display_mux #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic       blink_en,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BW = CW + 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [CW-1:0]     cnt;
  logic [2:0]        idx;
  logic [FW-1:0]     frame_cnt;
  logic              blink_phase;
  logic [7:0][5:0]   snapshot;
  logic [5:0]        cur;
  logic              load;
  logic              in_blank;
  logic              blank_all;
  logic [7:0]        an_nx;
  logic [6:0]        seg_nx;
  logic              dp_nx;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign cur       = snapshot[idx];
  assign load      = (idx == 3'd0) && (cnt == '0);
  assign blank_all = blink_en & blink_phase;

  // With no dead-time the compare would be constant, so drop it entirely.
  if (BLANK_CYCLES == 0) begin : g_blank_none
    assign in_blank = 1'b0;
  end else begin : g_blank
    localparam logic [BW-1:0] BLANK_LIM = BW'(BLANK_CYCLES);
    assign in_blank = ({1'b0, cnt} < BLANK_LIM);
  end

  // Segments follow the enabled digit even in the dead-time; only the anode blanks it.
  always_comb begin
    an_nx  = 8'hFF;
    seg_nx = 7'h7F;
    dp_nx  = 1'b1;
    if (cur[5]) begin
      seg_nx = hex7(cur[4:1]);
      dp_nx  = ~cur[0];
      if (!in_blank && !blank_all) begin
        an_nx = ~(8'h01 << idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= 3'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snapshot    <= '0;
      an_n        <= 8'hFF;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      frame_tick  <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      frame_tick <= load;
      if (load) begin
        snapshot <= {d8, d7, d6, d5, d4, d3, d2, d1};
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      an_n  <= an_nx;
      seg_n <= seg_nx;
      dp_n  <= dp_nx;
    end
  end

  // A dead-time covering the whole slot would leave the display permanently dark.
  always @(posedge clock) begin
    if (!reset) begin
      assert (BLANK_CYCLES < CLK_DIV);
    end
  end

endmodule

// File: tb/tb_seg8_display_mux.sv
// Directed bench for seg8_display_mux: a CLK_DIV=4/BLANK=1/BLINK=2 instance plus a CLK_DIV=1/BLANK=0 instance.
// Sample index i holds outputs derived from slot state cnt=i%4, idx=(i/4)%8 counted from reset release.
module tb_seg8_display_mux;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] d [8];
  logic       blink_en;
  logic [7:0] an_n, f_an_n;
  logic [6:0] seg_n, f_seg_n;
  logic       dp_n, f_dp_n;
  logic       frame_tick, f_frame_tick;

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [7:0] an_s  [170];
  logic [6:0] seg_s [170];
  logic       dp_s  [170];
  logic       ft_s  [170];
  logic [7:0] f_an_s [170];
  logic [6:0] f_seg_s[170];
  logic       f_ft_s [170];
  logic [6:0] glyph_ref [16];

  seg8_display_mux #(.CLK_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)) u_dut (
    .clock(clock), .reset(reset),
    .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]), .d5(d[4]), .d6(d[5]), .d7(d[6]), .d8(d[7]),
    .blink_en(blink_en), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_tick(frame_tick)
  );

  seg8_display_mux #(.CLK_DIV(1), .BLANK_CYCLES(0), .BLINK_FRAMES(2)) u_fast (
    .clock(clock), .reset(reset),
    .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]), .d5(d[4]), .d6(d[5]), .d7(d[6]), .d8(d[7]),
    .blink_en(blink_en), .an_n(f_an_n), .seg_n(f_seg_n), .dp_n(f_dp_n), .frame_tick(f_frame_tick)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      an_s[i] = an_n;  seg_s[i] = seg_n;  dp_s[i] = dp_n;  ft_s[i] = frame_tick;
      f_an_s[i] = f_an_n;  f_seg_s[i] = f_seg_n;  f_ft_s[i] = f_frame_tick;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_walk(input int base, input int dp_pos);
    for (int k = 0; k < 8; k++) d[k] = {1'b1, 4'(base + k), (k == dp_pos)};
  endtask

  task automatic test_reset();
    for (int k = 0; k < 8; k++) d[k] = 6'h00;
    blink_en = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk_cnt++; if (an_n !== 8'hFF) $display("FAIL reset_an an_n=%h exp=ff", an_n); else pass_cnt++;
    chk_cnt++; if (seg_n !== 7'h7F) $display("FAIL reset_seg seg_n=%h exp=7f", seg_n); else pass_cnt++;
    chk_cnt++; if (dp_n !== 1'b1) $display("FAIL reset_dp dp_n=%b exp=1", dp_n); else pass_cnt++;
    chk_cnt++; if (frame_tick !== 1'b0) $display("FAIL reset_tick frame_tick=%b exp=0", frame_tick); else pass_cnt++;
    chk_cnt++; if (f_an_n !== 8'hFF) $display("FAIL reset_fast_an an_n=%h exp=ff", f_an_n); else pass_cnt++;
  endtask

  task automatic test_single_digit();
    int lit, ticks;
    for (int k = 0; k < 8; k++) d[k] = 6'h00;
    d[0] = 6'b100010;
    do_reset();
    capture(36);
    chk_cnt++; if (ft_s[0] !== 1'b1) $display("FAIL single_tick0 frame_tick=%b exp=1", ft_s[0]); else pass_cnt++;
    chk_cnt++; if (an_s[0] !== 8'hFF) $display("FAIL single_blank an_n=%h exp=ff", an_s[0]); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      chk_cnt++; if (an_s[i] !== 8'hFE) $display("FAIL single_lit[%0d] an_n=%h exp=fe", i, an_s[i]); else pass_cnt++;
    end
    chk_cnt++; if (seg_s[1] !== 7'b1111001) $display("FAIL single_seg seg_n=%b exp=1111001", seg_s[1]); else pass_cnt++;
    lit = 0;
    ticks = 0;
    for (int i = 4; i < 32; i++) if (an_s[i] !== 8'hFF) lit++;
    for (int i = 1; i < 32; i++) if (ft_s[i] !== 1'b0) ticks++;
    chk_cnt++; if (lit !== 0) $display("FAIL single_dark lit_cycles=%0d exp=0", lit); else pass_cnt++;
    chk_cnt++; if (ticks !== 0) $display("FAIL single_tick_once extra_ticks=%0d exp=0", ticks); else pass_cnt++;
    chk_cnt++; if (ft_s[32] !== 1'b1) $display("FAIL single_tick32 frame_tick=%b exp=1", ft_s[32]); else pass_cnt++;
    chk_cnt++; if (an_s[33] !== 8'hFE) $display("FAIL single_frame1 an_n=%h exp=fe", an_s[33]); else pass_cnt++;
  endtask

  task automatic test_walk(input int base, input int dp_pos);
    logic [7:0] exp_an;
    int bad_dp, multi;
    set_walk(base, dp_pos);
    do_reset();
    capture(66);
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 4; c++) begin
        exp_an = (c == 0) ? 8'hFF : ~(8'h01 << p);
        chk_cnt++;
        if (an_s[4*p+c] !== exp_an) $display("FAIL walk%0d_an[%0d] an_n=%h exp=%h", base, 4*p+c, an_s[4*p+c], exp_an);
        else pass_cnt++;
      end
      chk_cnt++;
      if (seg_s[4*p+2] !== glyph_ref[base+p])
        $display("FAIL walk%0d_seg[%0d] seg_n=%b exp=%b", base, p, seg_s[4*p+2], glyph_ref[base+p]);
      else pass_cnt++;
    end
    bad_dp = 0;
    multi = 0;
    for (int i = 0; i < 32; i++) begin
      if (dp_s[i] !== ((dp_pos >= 0 && i >= 4*dp_pos && i < 4*dp_pos+4) ? 1'b0 : 1'b1)) bad_dp++;
      if ($countones(~an_s[i]) > 1) multi++;
    end
    chk_cnt++; if (bad_dp !== 0) $display("FAIL walk%0d_dp bad_cycles=%0d exp=0", base, bad_dp); else pass_cnt++;
    chk_cnt++; if (multi !== 0) $display("FAIL walk%0d_onehot bad_cycles=%0d exp=0", base, multi); else pass_cnt++;
    chk_cnt++; if (ft_s[31] !== 1'b0) $display("FAIL walk%0d_tick31 frame_tick=%b exp=0", base, ft_s[31]); else pass_cnt++;
    chk_cnt++; if (ft_s[32] !== 1'b1) $display("FAIL walk%0d_period frame_tick=%b exp=1", base, ft_s[32]); else pass_cnt++;
    chk_cnt++; if (an_s[33] !== 8'hFE) $display("FAIL walk%0d_wrap an_n=%h exp=fe", base, an_s[33]); else pass_cnt++;
  endtask

  task automatic test_midframe_change();
    for (int k = 0; k < 8; k++) d[k] = 6'h00;
    d[0] = 6'b100010;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      tick();
      an_s[i] = an_n;  seg_s[i] = seg_n;
      if (i == 1) d[0] = 6'b110000;
    end
    chk_cnt++; if (seg_s[3] !== 7'b1111001) $display("FAIL mid_hold seg_n=%b exp=1111001", seg_s[3]); else pass_cnt++;
    chk_cnt++; if (an_s[3] !== 8'hFE) $display("FAIL mid_hold_an an_n=%h exp=fe", an_s[3]); else pass_cnt++;
    chk_cnt++; if (seg_s[33] !== 7'b0000000) $display("FAIL mid_new seg_n=%b exp=0000000", seg_s[33]); else pass_cnt++;
    chk_cnt++; if (an_s[33] !== 8'hFE) $display("FAIL mid_new_an an_n=%h exp=fe", an_s[33]); else pass_cnt++;
  endtask

  // First load flips nothing; phase toggles on the second load, then every second load.
  task automatic test_blink();
    int lit0, lit12, lit34;
    set_walk(0, -1);
    blink_en = 1'b1;
    do_reset();
    capture(160);
    lit0 = 0; lit12 = 0; lit34 = 0;
    for (int i = 0; i < 32; i++)   if (an_s[i] !== 8'hFF) lit0++;
    for (int i = 32; i < 96; i++)  if (an_s[i] !== 8'hFF) lit12++;
    for (int i = 96; i < 160; i++) if (an_s[i] !== 8'hFF) lit34++;
    chk_cnt++; if (lit0 !== 24) $display("FAIL blink_f0 lit_cycles=%0d exp=24", lit0); else pass_cnt++;
    chk_cnt++; if (lit12 !== 0) $display("FAIL blink_f12 lit_cycles=%0d exp=0", lit12); else pass_cnt++;
    chk_cnt++; if (lit34 !== 48) $display("FAIL blink_f34 lit_cycles=%0d exp=48", lit34); else pass_cnt++;
    chk_cnt++; if (an_s[31] !== 8'h7F) $display("FAIL blink_last_lit an_n=%h exp=7f", an_s[31]); else pass_cnt++;
    chk_cnt++; if (an_s[97] !== 8'hFE) $display("FAIL blink_relit an_n=%h exp=fe", an_s[97]); else pass_cnt++;
    blink_en = 1'b0;
  endtask

  task automatic test_blink_release();
    set_walk(0, -1);
    blink_en = 1'b1;
    do_reset();
    capture(39);
    chk_cnt++; if (an_s[38] !== 8'hFF) $display("FAIL unblink_dark an_n=%h exp=ff", an_s[38]); else pass_cnt++;
    blink_en = 1'b0;
    tick();
    chk_cnt++; if (an_n !== 8'hFD) $display("FAIL unblink_restore an_n=%h exp=fd", an_n); else pass_cnt++;
  endtask

  task automatic test_blink_free_run();
    set_walk(0, -1);
    blink_en = 1'b0;
    do_reset();
    capture(39);
    chk_cnt++; if (an_s[38] !== 8'hFD) $display("FAIL freerun_lit an_n=%h exp=fd", an_s[38]); else pass_cnt++;
    blink_en = 1'b1;
    tick();
    chk_cnt++; if (an_n !== 8'hFF) $display("FAIL freerun_phase an_n=%h exp=ff", an_n); else pass_cnt++;
    blink_en = 1'b0;
  endtask

  task automatic test_reset_mid_slot();
    set_walk(0, 5);
    do_reset();
    capture(22);
    chk_cnt++; if (an_s[21] !== 8'hDF) $display("FAIL midrst_pre_an an_n=%h exp=df", an_s[21]); else pass_cnt++;
    chk_cnt++; if (dp_s[21] !== 1'b0) $display("FAIL midrst_pre_dp dp_n=%b exp=0", dp_s[21]); else pass_cnt++;
    reset = 1'b1;
    tick();
    chk_cnt++; if (an_n !== 8'hFF) $display("FAIL midrst_an an_n=%h exp=ff", an_n); else pass_cnt++;
    chk_cnt++; if (seg_n !== 7'h7F) $display("FAIL midrst_seg seg_n=%h exp=7f", seg_n); else pass_cnt++;
    chk_cnt++; if (dp_n !== 1'b1) $display("FAIL midrst_dp dp_n=%b exp=1", dp_n); else pass_cnt++;
    reset = 1'b0;
    capture(3);
    chk_cnt++; if (ft_s[0] !== 1'b1) $display("FAIL midrst_tick frame_tick=%b exp=1", ft_s[0]); else pass_cnt++;
    chk_cnt++; if (an_s[0] !== 8'hFF) $display("FAIL midrst_blank an_n=%h exp=ff", an_s[0]); else pass_cnt++;
    chk_cnt++; if (an_s[1] !== 8'hFE) $display("FAIL midrst_restart an_n=%h exp=fe", an_s[1]); else pass_cnt++;
    chk_cnt++; if (seg_s[1] !== glyph_ref[0]) $display("FAIL midrst_seg0 seg_n=%b exp=%b", seg_s[1], glyph_ref[0]); else pass_cnt++;
  endtask

  task automatic test_fast_scan();
    logic [7:0] exp_an;
    logic       exp_ft;
    set_walk(0, -1);
    blink_en = 1'b0;
    do_reset();
    capture(24);
    for (int i = 0; i < 24; i++) begin
      exp_an = (i == 0) ? 8'hFF : ~(8'h01 << (i % 8));
      exp_ft = ((i % 8) == 0);
      chk_cnt++;
      if (f_an_s[i] !== exp_an) $display("FAIL fast_an[%0d] an_n=%h exp=%h", i, f_an_s[i], exp_an); else pass_cnt++;
      chk_cnt++;
      if (f_ft_s[i] !== exp_ft) $display("FAIL fast_tick[%0d] frame_tick=%b exp=%b", i, f_ft_s[i], exp_ft); else pass_cnt++;
    end
    chk_cnt++; if (f_seg_s[3] !== glyph_ref[3]) $display("FAIL fast_seg seg_n=%b exp=%b", f_seg_s[3], glyph_ref[3]); else pass_cnt++;
  endtask

  initial begin
    glyph_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset = 1'b1;
    blink_en = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = 6'h00;

    test_reset();
    test_single_digit();
    test_walk(0, 2);
    test_walk(8, -1);
    test_midframe_change();
    test_blink();
    test_blink_release();
    test_blink_free_run();
    test_reset_mid_slot();
    test_fast_scan();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
